// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: load opcodes, load FSM states and load classes.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ld_state_t;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_t;

    // Access width plus sign-extension flag (set for LB/LH).
    typedef struct packed {
        ld_size_t size;
        logic     sgn;
    } ld_class_t;

endpackage

// File: rtl/load_extend.sv
// Little-endian lane select and sign/zero extension of a loaded word.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  ld_size_t    size,
    input  logic        sgn,
    output logic [31:0] data
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic s);
        return {{24{s & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic s);
        return {{16{s & h[15]}}, h};
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane and widen it to 32 bits.
    always_comb begin
        byte_lane = word[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (size)
            LD_BYTE: data = ext_byte(byte_lane, sgn);
            LD_HALF: data = ext_half(half_lane, sgn);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// MEM-stage load engine: alignment check, req/ack read with timeout, and
// extended result delivery to write-back.
module load_data_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Load_Req_M,
    input  logic [31:0] Instr_M,
    input  logic [31:0] ALU_Out_M,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    output logic        Stall_M,
    output logic [31:0] Load_Data_W,
    output logic        Load_Valid_W,
    output logic        Addr_Err,
    output logic        Bus_Err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    ld_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    ld_class_t        cls_q;
    logic [1:0]       off_q;

    ld_class_t        cls_d;
    logic             is_load;
    logic             misaligned;
    logic             load_ok;
    logic             load_bad;
    logic [31:0]      ext_data;
    logic             unused_instr;

    assign unused_instr = ^Instr_M[25:0];

    // Decode the opcode into a load class and qualify the request against alignment.
    always_comb begin
        is_load     = 1'b1;
        cls_d.size  = LD_WORD;
        cls_d.sgn   = 1'b0;
        case (Instr_M[31:26])
            OP_LB:   begin cls_d.size = LD_BYTE; cls_d.sgn = 1'b1; end
            OP_LBU:  cls_d.size = LD_BYTE;
            OP_LH:   begin cls_d.size = LD_HALF; cls_d.sgn = 1'b1; end
            OP_LHU:  cls_d.size = LD_HALF;
            OP_LW:   cls_d.size = LD_WORD;
            default: is_load = 1'b0;
        endcase
        misaligned = ((cls_d.size == LD_HALF) && ALU_Out_M[0]) ||
                     ((cls_d.size == LD_WORD) && (ALU_Out_M[1:0] != 2'b00));
        load_ok  = (state == IDLE) && Load_Req_M && is_load && !misaligned;
        load_bad = (state == IDLE) && Load_Req_M && is_load &&  misaligned;
    end

    // Freeze the front of the pipe while a read is being launched or awaited;
    // gated by rst_n so the stall drops the instant reset asserts.
    assign Stall_M = rst_n & (load_ok | (state == WAIT));

    load_extend u_extend (
        .word   (Mem_RData),
        .offset (off_q),
        .size   (cls_q.size),
        .sgn    (cls_q.sgn),
        .data   (ext_data)
    );

    // Load FSM, wait counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cls_q.size   <= LD_BYTE;
            cls_q.sgn    <= 1'b0;
            off_q        <= 2'b00;
            Mem_Req      <= 1'b0;
            Mem_Addr     <= '0;
            Load_Data_W  <= '0;
            Load_Valid_W <= 1'b0;
            Addr_Err     <= 1'b0;
            Bus_Err      <= 1'b0;
        end else begin
            Load_Valid_W <= 1'b0;
            Addr_Err     <= 1'b0;
            Bus_Err      <= 1'b0;
            case (state)
                IDLE: begin
                    Addr_Err <= load_bad;
                    if (load_ok) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                        cls_q    <= cls_d;
                        off_q    <= ALU_Out_M[1:0];
                        Mem_Req  <= 1'b1;
                        Mem_Addr <= {ALU_Out_M[31:2], 2'b00};
                    end
                end
                WAIT: begin
                    // An ack on the timeout cycle still counts as a good read.
                    if (Mem_Ack) begin
                        Load_Data_W  <= ext_data;
                        Load_Valid_W <= 1'b1;
                        Mem_Req      <= 1'b0;
                        state        <= RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        Load_Data_W  <= '0;
                        Load_Valid_W <= 1'b1;
                        Bus_Err      <= 1'b1;
                        Mem_Req      <= 1'b0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                // The instruction in MEM is still the completed load; ignore it.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboard bench for load_data_unit: stimulus pushes expected write-back
// responses, a monitor pops them whenever the DUT reports a result or error.
module tb_load_data_unit;

    localparam int TMO = 4;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] ADD = 6'b000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Load_Req_M;
    logic [31:0] Instr_M;
    logic [31:0] ALU_Out_M;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Stall_M;
    logic [31:0] Load_Data_W;
    logic        Load_Valid_W;
    logic        Addr_Err;
    logic        Bus_Err;

    load_data_unit #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Load_Req_M   (Load_Req_M),
        .Instr_M      (Instr_M),
        .ALU_Out_M    (ALU_Out_M),
        .Mem_Ack      (Mem_Ack),
        .Mem_RData    (Mem_RData),
        .Mem_Req      (Mem_Req),
        .Mem_Addr     (Mem_Addr),
        .Stall_M      (Stall_M),
        .Load_Data_W  (Load_Data_W),
        .Load_Valid_W (Load_Valid_W),
        .Addr_Err     (Addr_Err),
        .Bus_Err      (Bus_Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_addr_err;
        bit          bus_err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   req_rises = 0;
    int   exp_rises = 0;
    logic req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: value delivered to WB for a given load, by plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned v;
        int unsigned sh;
        v = word;
        case (op)
            LB, LBU: begin
                sh = 8 * int'(addr % 4);
                v  = (word >> sh) % 256;
                if (op == LB && v >= 128) v = v - 256;
            end
            LH, LHU: begin
                sh = 16 * int'((addr / 2) % 2);
                v  = (word >> sh) % 65536;
                if (op == LH && v >= 32768) v = v - 65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            LB, LBU: return 1;
            LH, LHU: return 2;
            LW:      return 4;
            default: return 0;
        endcase
    endfunction

    // Monitor: every result/error pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (Load_Valid_W || Addr_Err || Bus_Err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out valid=%0b addr_err=%0b bus_err=%0b required=none",
                         Load_Valid_W, Addr_Err, Bus_Err);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_addr_err) begin
                    chk("flags_addr_err", {29'd0, Addr_Err, Load_Valid_W, Bus_Err}, 32'b100);
                end else begin
                    chk("flags_load", {29'd0, Addr_Err, Load_Valid_W, Bus_Err},
                        {29'd0, 1'b0, 1'b1, mon_e.bus_err});
                    chk("load_data", Load_Data_W, mon_e.data);
                end
            end
        end
    end

    // Count request launches so duplicate or missing requests show up.
    always @(negedge clk) begin
        if (Mem_Req && !req_prev) req_rises++;
        req_prev <= Mem_Req;
    end

    // One load-stage instruction; delay < 0 means memory never acks.
    task automatic do_op(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input int delay);
        int   nb;
        bit   legal;
        bit   mis;
        exp_t e;
        @(negedge clk);
        Load_Req_M = 1'b1;
        Instr_M    = {op, 26'($urandom)};
        ALU_Out_M  = addr;
        Mem_Ack    = 1'b0;
        Mem_RData  = $urandom;
        nb    = op_bytes(op);
        mis   = (nb != 0) && ((addr % nb) != 0);
        legal = (nb != 0) && !mis;
        #1;
        chk("stall_c0", {31'd0, Stall_M}, {31'd0, legal});
        chk("req_c0", {31'd0, Mem_Req}, 32'd0);
        if (legal) begin
            exp_rises++;
            e.is_addr_err = 1'b0;
            e.bus_err     = (delay < 0);
            e.data        = (delay < 0) ? 32'd0 : ref_load(op, addr, rdata);
            sb.push_back(e);
            for (int c = 1; c <= TMO + 1; c++) begin
                @(negedge clk);
                chk("req_wait", {31'd0, Mem_Req}, 32'd1);
                chk("addr_wait", Mem_Addr, {addr[31:2], 2'b00});
                chk("stall_wait", {31'd0, Stall_M}, 32'd1);
                Mem_Ack   = (c == 1 + delay);
                Mem_RData = Mem_Ack ? rdata : $urandom;
                if (Mem_Ack) break;
            end
            @(negedge clk);
            Mem_Ack = 1'b0;
            chk("valid_resp", {31'd0, Load_Valid_W}, 32'd1);
            chk("req_resp", {31'd0, Mem_Req}, 32'd0);
            chk("stall_resp", {31'd0, Stall_M}, 32'd0);
        end else begin
            if (mis) begin
                e.is_addr_err = 1'b1;
                e.bus_err     = 1'b0;
                e.data        = '0;
                sb.push_back(e);
            end
            @(negedge clk);
            Load_Req_M = 1'b0;
            chk("req_noissue", {31'd0, Mem_Req}, 32'd0);
            chk("stall_noissue", {31'd0, Stall_M}, 32'd0);
            chk("addr_err_c1", {31'd0, Addr_Err}, {31'd0, mis});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            Load_Req_M = 1'b0;
            Mem_Ack    = 1'b0;
        end
    endtask

    // Reset in the middle of a wait: request and stall drop at once, a late ack is ignored.
    task automatic reset_mid_wait();
        @(negedge clk);
        Load_Req_M = 1'b1;
        Instr_M    = {LW, 26'd0};
        ALU_Out_M  = 32'h0000_4000;
        Mem_Ack    = 1'b0;
        exp_rises++;
        repeat (2) @(negedge clk);
        chk("req_before_rst", {31'd0, Mem_Req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("req_async_rst", {31'd0, Mem_Req}, 32'd0);
        chk("stall_async_rst", {31'd0, Stall_M}, 32'd0);
        Load_Req_M = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        Mem_Ack   = 1'b1;
        Mem_RData = 32'hDEAD_BEEF;
        @(negedge clk);
        Mem_Ack = 1'b0;
        chk("late_ack_valid", {31'd0, Load_Valid_W}, 32'd0);
        chk("late_ack_req", {31'd0, Mem_Req}, 32'd0);
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [5:0]  op;
        logic [31:0] addr;
        int          nb;
        ops = '{LB, LH, LW, LBU, LHU, ADD};

        rst_n      = 1'b0;
        Load_Req_M = 1'b1;
        Instr_M    = {LW, 26'd0};
        ALU_Out_M  = 32'h0000_0010;
        Mem_Ack    = 1'b1;
        Mem_RData  = '1;
        #12;
        chk("rst_mem_req", {31'd0, Mem_Req}, 32'd0);
        chk("rst_mem_addr", Mem_Addr, 32'd0);
        chk("rst_stall", {31'd0, Stall_M}, 32'd0);
        chk("rst_data", Load_Data_W, 32'd0);
        chk("rst_valid", {31'd0, Load_Valid_W}, 32'd0);
        chk("rst_addr_err", {31'd0, Addr_Err}, 32'd0);
        chk("rst_bus_err", {31'd0, Bus_Err}, 32'd0);
        Load_Req_M = 1'b0;
        Mem_Ack    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(LB,  32'h0000_1003, 32'h80FF_1234, 0);
        idle(1);
        do_op(LBU, 32'h0000_2002, 32'hBEEF_0000, 4);
        idle(1);
        do_op(LHU, 32'h0000_2002, 32'hBEEF_0000, 4);
        idle(1);
        do_op(LH,  32'h0000_2002, 32'hBEEF_0000, 4);
        idle(1);
        do_op(LW,  32'h0000_3001, 32'h1111_1111, 0);
        do_op(LH,  32'h0000_3001, 32'h1111_1111, 0);
        idle(1);
        do_op(LW,  32'h0000_5000, 32'h1234_5678, -1);
        idle(1);
        do_op(ADD, 32'h0000_5000, 32'h1234_5678, 0);
        reset_mid_wait();
        do_op(LW,  32'h0000_6004, 32'hCAFE_F00D, 1);
        do_op(LW,  32'h0000_6008, 32'h0BAD_F00D, 0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            op   = ops[$urandom_range(0, 5)];
            addr = $urandom;
            nb   = op_bytes(op);
            if (nb != 0 && $urandom_range(0, 2) != 0) addr = addr & ~(32'(nb) - 32'd1);
            do_op(op, addr, $urandom, int'($urandom_range(0, TMO + 1)) - 1);
            idle($urandom_range(0, 2));
        end
        idle(3);

        chk("sb_drained", sb.size(), 32'd0);
        chk("req_count", req_rises, exp_rises);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time_limit_reached required=finish");
        $fatal(1);
    end

endmodule
